// File: rtl/kgp_wb_pkg.sv
// Shared constants and types for the KGP-RISC register-file writeback stage.
package kgp_wb_pkg;

  localparam logic [2:0] OP_ALU0 = 3'd0;
  localparam logic [2:0] OP_ALU1 = 3'd1;
  localparam logic [2:0] OP_MEM  = 3'd2;
  localparam logic [2:0] OP_BR   = 3'd3;

  localparam logic [3:0] FC_LD   = 4'd0;
  localparam logic [3:0] FC_CALL = 4'd9;
  localparam logic [3:0] FC_SHX0 = 4'd10;
  localparam logic [3:0] FC_SHX1 = 4'd11;
  localparam logic [3:0] FC_WIDE = 4'd12;

  typedef enum logic {
    S_RUN = 1'b0,
    S_EXT = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational decode of an opcode/fcode result bundle into one register-file write.
module wb_decode
  import kgp_wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LINK_REG = 31,
  parameter int EXT_REG  = 20
) (
  input  logic [2:0]      opcode,
  input  logic [3:0]      fcode,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] ra,
  input  logic [XLEN-1:0] mem_out,
  output logic            dec_we,
  output logic [AW-1:0]   dec_addr,
  output logic [XLEN-1:0] dec_data,
  output logic            dec_wide
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);
  localparam logic [AW-1:0] EXT_A  = AW'(EXT_REG);

  always_comb begin
    dec_we   = 1'b0;
    dec_addr = '0;
    dec_data = '0;
    dec_wide = 1'b0;
    case (opcode)
      OP_BR: begin
        if (fcode == FC_CALL) begin
          dec_we   = 1'b1;
          dec_addr = LINK_A;
          dec_data = ra;
        end
      end
      OP_ALU0, OP_ALU1: begin
        dec_we   = 1'b1;
        dec_data = alu_out;
        dec_addr = (fcode == FC_SHX0 || fcode == FC_SHX1) ? EXT_A : rs_addr;
        dec_wide = (fcode == FC_WIDE);
      end
      OP_MEM: begin
        if (fcode == FC_LD) begin
          dec_we   = 1'b1;
          dec_addr = rt_addr;
          dec_data = mem_out;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback stage: one write per accepted bundle, wide results take a
// second cycle to write their upper half to EXT_REG while upstream is stalled.
module wb_stage
  import kgp_wb_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NREG           = 32,
  parameter int LINK_REG       = 31,
  parameter int EXT_REG        = 20,
  parameter int ZERO_HARDWIRED = 1,
  parameter int CNT_W          = 32,
  localparam int AW            = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [2:0]       opcode,
  input  logic [3:0]       fcode,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  input  logic [XLEN-1:0]  alu_out,
  input  logic [XLEN-1:0]  alu_ext_out,
  input  logic [XLEN-1:0]  ra,
  input  logic [XLEN-1:0]  mem_out,
  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic [CNT_W-1:0] retired
);

  localparam logic [AW-1:0] EXT_A = AW'(EXT_REG);

  wb_state_t        state_q, state_d;
  logic             we_q, we_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [XLEN-1:0]  wdata_q, wdata_d;
  logic [XLEN-1:0]  ext_q, ext_d;
  logic [CNT_W-1:0] ret_q, ret_d;

  logic             dec_we, dec_wide;
  logic [AW-1:0]    dec_addr;
  logic [XLEN-1:0]  dec_data;
  logic             accept;

  function automatic logic gate_we(input logic we, input logic [AW-1:0] addr);
    return we && !((ZERO_HARDWIRED != 0) && (addr == '0));
  endfunction

  wb_decode #(
    .XLEN(XLEN), .AW(AW), .LINK_REG(LINK_REG), .EXT_REG(EXT_REG)
  ) u_decode (
    .opcode  (opcode),
    .fcode   (fcode),
    .rs_addr (rs_addr),
    .rt_addr (rt_addr),
    .alu_out (alu_out),
    .ra      (ra),
    .mem_out (mem_out),
    .dec_we  (dec_we),
    .dec_addr(dec_addr),
    .dec_data(dec_data),
    .dec_wide(dec_wide)
  );

  assign in_ready = (state_q == S_RUN);
  assign accept   = in_valid && in_ready && !flush;

  // Address/data hold on idle cycles; only the enable drops.
  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    ext_d   = ext_q;
    ret_d   = ret_q;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          we_d    = gate_we(dec_we, dec_addr);
          waddr_d = dec_addr;
          wdata_d = dec_data;
          ret_d   = ret_q + CNT_W'(1);
          if (dec_wide) begin
            state_d = S_EXT;
            ext_d   = alu_ext_out;
          end
        end
      end
      S_EXT: begin
        state_d = S_RUN;
        ext_d   = '0;
        if (!flush) begin
          we_d    = gate_we(1'b1, EXT_A);
          waddr_d = EXT_A;
          wdata_d = ext_q;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      ext_q   <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ext_q   <= ext_d;
      ret_q   <= ret_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign retired  = ret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: two instances (zero-reg hardwired with 32-bit counter, and
// zero-reg writable with 3-bit counter) share stimulus and are checked against a model.
module tb_wb_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0;
  logic [2:0]  opcode = '0;
  logic [3:0]  fcode = '0;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] alu_out = '0, alu_ext_out = '0, ra = '0, mem_out = '0;

  logic        in_ready_a, rf_we_a, in_ready_b, rf_we_b;
  logic [4:0]  rf_waddr_a, rf_waddr_b;
  logic [31:0] rf_wdata_a, rf_wdata_b, retired_a;
  logic [2:0]  retired_b;

  wb_stage dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .flush(flush),
    .opcode(opcode), .fcode(fcode), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_out(alu_out), .alu_ext_out(alu_ext_out), .ra(ra), .mem_out(mem_out),
    .rf_we(rf_we_a), .rf_waddr(rf_waddr_a), .rf_wdata(rf_wdata_a), .retired(retired_a)
  );

  wb_stage #(.ZERO_HARDWIRED(0), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .flush(flush),
    .opcode(opcode), .fcode(fcode), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .alu_out(alu_out), .alu_ext_out(alu_ext_out), .ra(ra), .mem_out(mem_out),
    .rf_we(rf_we_b), .rf_waddr(rf_waddr_b), .rf_wdata(rf_wdata_b), .retired(retired_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: pending upper half, last write, and an unbounded retire count.
  bit          m_busy = 1'b0;
  logic [31:0] m_ext = '0;
  bit          m_we_a = 1'b0, m_we_b = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  int unsigned m_ret = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_decode(output bit w, output logic [4:0] a,
                                     output logic [31:0] d, output bit wide);
    w = 1'b0; a = '0; d = '0; wide = 1'b0;
    if (opcode == 3'd3 && fcode == 4'd9) begin
      w = 1'b1; a = 5'd31; d = ra;
    end else if (opcode == 3'd0 || opcode == 3'd1) begin
      w = 1'b1; d = alu_out;
      a = (fcode == 4'd10 || fcode == 4'd11) ? 5'd20 : rs_addr;
      wide = (fcode == 4'd12);
    end else if (opcode == 3'd2 && fcode == 4'd0) begin
      w = 1'b1; a = rt_addr; d = mem_out;
    end
  endfunction

  function automatic void model_reset();
    m_busy = 1'b0; m_ext = '0; m_we_a = 1'b0; m_we_b = 1'b0;
    m_addr = '0; m_data = '0; m_ret = 0;
  endfunction

  function automatic void model_edge();
    bit w, wide;
    logic [4:0] a;
    logic [31:0] d;
    if (m_busy) begin
      m_busy = 1'b0;
      if (flush) begin
        m_we_a = 1'b0; m_we_b = 1'b0;
      end else begin
        m_we_a = 1'b1; m_we_b = 1'b1; m_addr = 5'd20; m_data = m_ext;
      end
    end else if (in_valid && !flush) begin
      ref_decode(w, a, d, wide);
      m_addr = a; m_data = d;
      m_we_a = w && (a != 5'd0);
      m_we_b = w;
      m_ret  = m_ret + 1;
      if (wide) begin
        m_busy = 1'b1; m_ext = alu_ext_out;
      end
    end else begin
      m_we_a = 1'b0; m_we_b = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".we_a"},    32'(rf_we_a),    32'(m_we_a));
    chk({tag, ".we_b"},    32'(rf_we_b),    32'(m_we_b));
    chk({tag, ".addr_a"},  32'(rf_waddr_a), 32'(m_addr));
    chk({tag, ".addr_b"},  32'(rf_waddr_b), 32'(m_addr));
    chk({tag, ".data_a"},  rf_wdata_a,      m_data);
    chk({tag, ".data_b"},  rf_wdata_b,      m_data);
    chk({tag, ".rdy_a"},   32'(in_ready_a), 32'(!m_busy));
    chk({tag, ".rdy_b"},   32'(in_ready_b), 32'(!m_busy));
    chk({tag, ".ret_a"},   retired_a,       m_ret);
    chk({tag, ".ret_b"},   32'(retired_b),  m_ret % 8);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic f, input logic [2:0] op, input logic [3:0] fc,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] alu,
                       input logic [31:0] ext, input logic [31:0] ra_v, input logic [31:0] mem);
    in_valid = v; flush = f; opcode = op; fcode = fc; rs_addr = rs; rt_addr = rt;
    alu_out = alu; alu_ext_out = ext; ra = ra_v; mem_out = mem;
  endtask

  int unsigned ret_before;
  logic [3:0]  fc_pick [6];

  initial begin
    fc_pick[0] = 4'd0;  fc_pick[1] = 4'd9;  fc_pick[2] = 4'd10;
    fc_pick[3] = 4'd11; fc_pick[4] = 4'd12; fc_pick[5] = 4'd5;

    // Power-on reset
    #2 rst_n = 1'b0;
    #2 model_reset();
    check_all("reset");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
    tick("idle");

    // Call writes link register
    ret_before = m_ret;
    drive(1, 0, 3'd3, 4'd9, 5'd2, 5'd3, 32'h11, 32'h22, 32'h104, 32'h33);
    tick("call");
    chk("call.we", 32'(rf_we_a), 32'd1);
    chk("call.addr", 32'(rf_waddr_a), 32'd31);
    chk("call.data", rf_wdata_a, 32'h104);
    chk("call.ret", retired_a, ret_before + 1);

    // Wide result, with the following bundle held during the stall cycle
    drive(1, 0, 3'd0, 4'd12, 5'd5, 5'd0, 32'h89ABCDEF, 32'h01234567, 32'h0, 32'h0);
    tick("wide1");
    chk("wide1.addr", 32'(rf_waddr_a), 32'd5);
    chk("wide1.data", rf_wdata_a, 32'h89ABCDEF);
    chk("wide1.rdy", 32'(in_ready_a), 32'd0);
    drive(1, 0, 3'd3, 4'd9, 5'd0, 5'd0, 32'h0, 32'h0, 32'h200, 32'h0);
    tick("wide2");
    chk("wide2.we", 32'(rf_we_a), 32'd1);
    chk("wide2.addr", 32'(rf_waddr_a), 32'd20);
    chk("wide2.data", rf_wdata_a, 32'h01234567);
    chk("wide2.rdy", 32'(in_ready_a), 32'd1);
    tick("held");
    chk("held.addr", 32'(rf_waddr_a), 32'd31);
    chk("held.data", rf_wdata_a, 32'h200);

    // Flush during the upper-half cycle, then flush against a valid load
    drive(1, 0, 3'd1, 4'd12, 5'd9, 5'd0, 32'hAAAA5555, 32'h5A5A5A5A, 32'h0, 32'h0);
    tick("fwide");
    drive(0, 1, 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick("fext");
    chk("fext.we", 32'(rf_we_a), 32'd0);
    ret_before = m_ret;
    drive(1, 1, 3'd2, 4'd0, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 32'hCAFE);
    tick("fload");
    chk("fload.we", 32'(rf_we_a), 32'd0);
    chk("fload.ret", retired_a, ret_before);

    // Register 0 writes: suppressed on A, performed on B
    drive(1, 0, 3'd1, 4'd0, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0, 32'h0);
    tick("zero");
    chk("zero.we_a", 32'(rf_we_a), 32'd0);
    chk("zero.we_b", 32'(rf_we_b), 32'd1);
    chk("zero.addr_b", 32'(rf_waddr_b), 32'd0);

    // Back-to-back loads; B's 3-bit counter wraps
    for (int i = 1; i <= 8; i++) begin
      drive(1, 0, 3'd2, 4'd0, 5'd0, 5'(i), 32'h0, 32'h0, 32'h0, 32'h1000 + 32'(i));
      tick("load");
      chk("load.we", 32'(rf_we_a), 32'd1);
      chk("load.addr", 32'(rf_waddr_a), 32'(i));
    end

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
            3'($urandom_range(0, 7)), fc_pick[$urandom_range(0, 5)],
            5'($urandom), 5'($urandom), $urandom, $urandom, $urandom, $urandom);
      tick("rand");
    end

    // Asynchronous reset while an upper half is pending
    drive(1, 0, 3'd0, 4'd12, 5'd3, 5'd0, 32'h1111, 32'hDEAD0000, 32'h0, 32'h0);
    tick("rwide");
    drive(0, 0, 3'd0, 4'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    rst_n = 1'b0;
    #1 model_reset();
    chk("rst.we", 32'(rf_we_a), 32'd0);
    chk("rst.ret", retired_a, 32'd0);
    check_all("rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick("post1");
    chk("post1.we", 32'(rf_we_a), 32'd0);
    tick("post2");
    chk("post2.addr", 32'(rf_waddr_a), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
